fft_power_spec: RTL and testbench

FFT_POWER_SPEC -- requirements
Module: fft_power_spec

---
 rtl/pspec_pkg.sv | 24 ++
 rtl/pspec_sq_pipe.sv | 55 +++++
 rtl/fft_power_spec.sv | 144 ++++++++++++++
 tb/tb_fft_power_spec.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pspec_pkg.sv
// Shared types and Q-format helpers for the fft_power_spec power-spectrum block.
// Optional build macro PSPEC_SAT_CNT_EN adds a per-frame saturation counter.
package pspec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } pspec_state_t;

  localparam int IDX_W     = 9;
  localparam int SAT_CNT_W = 9;

  // Rounding offset 2^(w-2), which is 0x4000 for Q1.15.
  function automatic longint rnd_ofs(input int width);
    return longint'(1) << (width - 2);
  endfunction

  // Largest positive Q1.(w-1) value, which is 0x7FFF for Q1.15.
  function automatic longint sat_max(input int width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/pspec_sq_pipe.sv
// Two-stage |X|^2 datapath: stage 1 squares and sums at full precision,
// stage 2 rounds, shifts back to Q1.15 and saturates. Sideband lives in the top.
module pspec_sq_pipe
  import pspec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s1_en,
  input  logic             s2_en,
  input  logic [WIDTH-1:0] re,
  input  logic [WIDTH-1:0] im,
`ifdef PSPEC_SAT_CNT_EN
  output logic             s1_sat,
`endif
  output logic [WIDTH-1:0] pwr
);

  localparam int            PW  = 2 * WIDTH + 1;
  localparam logic [PW-1:0] RND = PW'(rnd_ofs(WIDTH));
  localparam logic [PW-1:0] SAT = PW'(sat_max(WIDTH));

  logic signed [2*WIDTH-1:0] re_sq;
  logic signed [2*WIDTH-1:0] im_sq;
  logic        [PW-1:0]      sum_d;
  logic        [PW-1:0]      sum_q;
  logic        [PW-1:0]      shifted;
  logic                      sat;

  // Squares are never negative, so the sum is held unsigned at full width.
  always_comb begin
    re_sq   = $signed(re) * $signed(re);
    im_sq   = $signed(im) * $signed(im);
    sum_d   = PW'($unsigned(re_sq)) + PW'($unsigned(im_sq));
    shifted = (sum_q + RND) >> (WIDTH - 1);
    sat     = shifted > SAT;
  end

`ifdef PSPEC_SAT_CNT_EN
  assign s1_sat = sat;
`endif

  // NOTE: registers take <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      pwr   <= '0;
    end else begin
      if (s1_en) sum_q <= sum_d;
      if (s2_en) pwr   <= sat ? SAT[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fft_power_spec.sv
// One-sided power spectrum: forwards |X[k]|^2 for bins 0..N_BIN-1 of each FFT
// frame and drops the mirrored half. Build macro PSPEC_SAT_CNT_EN adds sat_cnt.
module fft_power_spec
  import pspec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N_FFT = 512,
  parameter int N_BIN = N_FFT / 2 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fft_vld,
  input  logic                 fft_sof,
  input  logic [WIDTH-1:0]     fft_re,
  input  logic [WIDTH-1:0]     fft_im,
  output logic                 fft_bin_vld,
  output logic [WIDTH-1:0]     fft_bin,
  output logic [IDX_W-1:0]     fft_bin_idx,
  output logic                 frame_done,
  output logic                 sof_err
`ifdef PSPEC_SAT_CNT_EN
  ,
  output logic [SAT_CNT_W-1:0] sat_cnt
`endif
);

  localparam int               CNT_W     = $clog2(N_FFT);
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(N_BIN - 1);
  localparam logic [CNT_W-1:0] LAST_FFT  = CNT_W'(N_FFT - 1);

  pspec_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sof_acc;
  logic             fwd, fwd_last, err;
  logic [IDX_W-1:0] fwd_idx;
  logic             vld_s1, last_s1;
  logic [IDX_W-1:0] idx_s1;

  assign sof_acc = fft_vld & fft_sof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A qualified sof always (re)starts a frame, whatever state we are in.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sof_acc) state_nxt = ST_PASS;
      ST_PASS: begin
        if (sof_acc)                           state_nxt = ST_PASS;
        else if (fft_vld && cnt == LAST_PASS)  state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (sof_acc)                           state_nxt = ST_PASS;
        else if (fft_vld && cnt == LAST_FFT)   state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every output of a combinational block gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    fwd      = 1'b0;
    fwd_last = 1'b0;
    err      = 1'b0;
    cnt_nxt  = cnt;
    fwd_idx  = fft_sof ? '0 : IDX_W'(cnt);
    if (sof_acc) begin
      fwd     = 1'b1;
      err     = (state != ST_IDLE);
      cnt_nxt = CNT_W'(1);
    end else if (fft_vld) begin
      case (state)
        ST_PASS: begin
          fwd      = 1'b1;
          fwd_last = (cnt == LAST_PASS);
          cnt_nxt  = cnt + CNT_W'(1);
        end
        ST_DROP: cnt_nxt = (cnt == LAST_FFT) ? '0 : cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Index and last-bin flag travel through two stages to stay aligned with fft_bin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      sof_err     <= 1'b0;
      vld_s1      <= 1'b0;
      last_s1     <= 1'b0;
      idx_s1      <= '0;
      fft_bin_vld <= 1'b0;
      frame_done  <= 1'b0;
      fft_bin_idx <= '0;
    end else begin
      cnt         <= cnt_nxt;
      sof_err     <= err;
      vld_s1      <= fwd;
      last_s1     <= fwd_last;
      fft_bin_vld <= vld_s1;
      frame_done  <= last_s1;
      if (fwd)    idx_s1      <= fwd_idx;
      if (vld_s1) fft_bin_idx <= idx_s1;
    end
  end

`ifdef PSPEC_SAT_CNT_EN
  logic                 s1_sat;
  logic [SAT_CNT_W-1:0] sat_acc;
  logic [SAT_CNT_W-1:0] sat_sum;

  // Bin 0 restarts the tally, so an aborted frame never reaches sat_cnt.
  assign sat_sum = ((idx_s1 == '0) ? '0 : sat_acc) + SAT_CNT_W'(s1_sat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_acc <= '0;
      sat_cnt <= '0;
    end else if (vld_s1) begin
      sat_acc <= sat_sum;
      if (last_s1) sat_cnt <= sat_sum;
    end
  end
`endif

  pspec_sq_pipe #(
    .WIDTH (WIDTH)
  ) u_sq_pipe (
    .clk    (clk),
    .rst    (rst),
    .s1_en  (fwd),
    .s2_en  (vld_s1),
    .re     (fft_re),
    .im     (fft_im),
`ifdef PSPEC_SAT_CNT_EN
    .s1_sat (s1_sat),
`endif
    .pwr    (fft_bin)
  );

endmodule

// File: tb/tb_fft_power_spec.sv
// Self-checking bench for fft_power_spec: randomized frames against a
// stream-level reference model, plus directed Q1.15 vectors and reset cases.
module tb_fft_power_spec;

  localparam int N_FFT = 512;
  localparam int N_BIN = 257;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_vld = 1'b0;
  logic        fft_sof = 1'b0;
  logic [15:0] fft_re = '0;
  logic [15:0] fft_im = '0;
  logic        fft_bin_vld;
  logic [15:0] fft_bin;
  logic [8:0]  fft_bin_idx;
  logic        frame_done;
  logic        sof_err;
`ifdef PSPEC_SAT_CNT_EN
  logic [8:0]  sat_cnt;
`endif

  fft_power_spec dut (
    .clk         (clk),
    .rst         (rst),
    .fft_vld     (fft_vld),
    .fft_sof     (fft_sof),
    .fft_re      (fft_re),
    .fft_im      (fft_im),
    .fft_bin_vld (fft_bin_vld),
    .fft_bin     (fft_bin),
    .fft_bin_idx (fft_bin_idx),
    .frame_done  (frame_done),
`ifdef PSPEC_SAT_CNT_EN
    .sat_cnt     (sat_cnt),
`endif
    .sof_err     (sof_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned edge_no;
    logic [8:0]  idx;
    logic [15:0] bin;
    logic        done;
    logic [8:0]  sat;
  } ent_t;

  ent_t        exp_q[$], obs_q[$];
  int unsigned err_exp[$], err_obs[$];
  int unsigned edge_n = 0;
  int          n_cmp = 0, n_bad = 0;

  bit m_in  = 1'b0;
  int m_pos = 0;
  int m_sat = 0;

  // Monitor: everything the DUT emits, tagged with the clock edge it appeared on.
  initial begin
    ent_t x;
    forever begin
      @(posedge clk);
      #1;
      edge_n = edge_n + 1;
      if (fft_bin_vld || frame_done) begin
        x.edge_no = edge_n;
        x.idx     = fft_bin_idx;
        x.bin     = fft_bin;
        x.done    = frame_done;
        x.sat     = '0;
`ifdef PSPEC_SAT_CNT_EN
        if (frame_done) x.sat = sat_cnt;
`endif
        obs_q.push_back(x);
      end
      if (sof_err) err_obs.push_back(edge_n);
    end
  end

  function automatic longint raw_pwr(logic signed [15:0] re, logic signed [15:0] im);
    longint a = re;
    longint b = im;
    return (a * a + b * b + 64'd16384) >>> 15;
  endfunction

  // Reference: the sample's position within its frame decides whether it emits.
  task automatic model_step(bit sof, logic [15:0] re, logic [15:0] im, int unsigned e);
    ent_t   x;
    longint r;
    if (sof) begin
      if (m_in) err_exp.push_back(e);
      m_in  = 1'b1;
      m_pos = 0;
      m_sat = 0;
    end else if (m_in) begin
      m_pos++;
    end else begin
      return;
    end
    if (m_pos < N_BIN) begin
      r         = raw_pwr(re, im);
      x.edge_no = e + 1;
      x.idx     = 9'(m_pos);
      x.bin     = (r > 32767) ? 16'h7FFF : 16'(r);
      x.done    = (m_pos == N_BIN - 1);
      if (r > 32767) m_sat++;
      x.sat     = '0;
`ifdef PSPEC_SAT_CNT_EN
      if (x.done) x.sat = 9'(m_sat);
`endif
      exp_q.push_back(x);
    end
    if (m_pos == N_FFT - 1) m_in = 1'b0;
  endtask

  task automatic put(bit v, bit s, logic [15:0] re, logic [15:0] im);
    @(negedge clk);
    fft_vld = v;
    fft_sof = s;
    fft_re  = re;
    fft_im  = im;
    if (v) model_step(s, re, im, edge_n + 1);
  endtask

  function automatic logic [15:0] rnd_full();
    return 16'($urandom_range(0, 65535));
  endfunction

  function automatic logic [15:0] rnd_small();
    int v = int'($urandom_range(0, 32767)) - 16384;
    return 16'(v);
  endfunction

  task automatic idle(int n);
    repeat (n) put(1'b0, 1'($urandom_range(0, 1)), rnd_full(), rnd_full());
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (fft_bin_vld !== 1'b0) begin n_bad++; $display("FAIL reset fft_bin_vld: got %b want 0", fft_bin_vld); end
    n_cmp++; if (fft_bin !== 16'h0)    begin n_bad++; $display("FAIL reset fft_bin: got %h want 0000", fft_bin); end
    n_cmp++; if (fft_bin_idx !== 9'h0) begin n_bad++; $display("FAIL reset fft_bin_idx: got %0d want 0", fft_bin_idx); end
    n_cmp++; if (frame_done !== 1'b0)  begin n_bad++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    n_cmp++; if (sof_err !== 1'b0)     begin n_bad++; $display("FAIL reset sof_err: got %b want 0", sof_err); end
    rst = 1'b0;
    repeat (5) put(1'b1, 1'b0, rnd_full(), rnd_full());
    repeat (3) put(1'b0, 1'b1, rnd_full(), rnd_full());
    idle(4);
    n_cmp++; if (obs_q.size() != 0)   begin n_bad++; $display("FAIL idle_no_sof outputs: got %0d want 0", obs_q.size()); end
    n_cmp++; if (err_obs.size() != 0) begin n_bad++; $display("FAIL idle_no_sof sof_err: got %0d want 0", err_obs.size()); end
    obs_q.delete(); err_obs.delete();
  endtask

  task automatic test_vectors;
    logic [15:0] want_v[4];
    int unsigned sof_edge;
    want_v = '{16'h7FFF, 16'h2000, 16'h0002, 16'h0000};
    put(1'b1, 1'b1, 16'h8000, 16'h8000);
    sof_edge = edge_n + 1;
    put(1'b1, 1'b0, 16'h4000, 16'h0000);
    put(1'b1, 1'b0, 16'h00B5, 16'h00B5);
    put(1'b1, 1'b0, 16'h0001, 16'h0001);
    for (int i = 4; i < N_FFT; i++) put(1'b1, 1'b0, rnd_small(), rnd_small());
    idle(5);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_q.size() <= i) begin
        n_bad++; $display("FAIL vectors bin%0d: got nothing want %h", i, want_v[i]);
      end else if (obs_q[i].bin !== want_v[i] || obs_q[i].edge_no != sof_edge + i + 1) begin
        n_bad++;
        $display("FAIL vectors bin%0d: got %h at edge %0d want %h at edge %0d",
                 i, obs_q[i].bin, obs_q[i].edge_no, want_v[i], sof_edge + i + 1);
      end
    end
`ifdef PSPEC_SAT_CNT_EN
    n_cmp++;
    if (obs_q.size() < N_BIN || obs_q[N_BIN-1].sat !== 9'd1) begin
      n_bad++; $display("FAIL vectors sat_cnt: got %0d want 1", (obs_q.size() < N_BIN) ? -1 : int'(obs_q[N_BIN-1].sat));
    end
`endif
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL vectors bin_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL vectors out[%0d]: got %p want %p", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (err_obs.size() != err_exp.size()) begin n_bad++; $display("FAIL vectors sof_err_count: got %0d want %0d", err_obs.size(), err_exp.size()); end
    obs_q.delete(); exp_q.delete(); err_obs.delete(); err_exp.delete();
  endtask

  task automatic test_full_frames;
    int i;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N_FFT; k++) put(1'b1, k == 0, rnd_full(), rnd_full());
    i = 0;
    while (i < N_FFT) begin
      if ($urandom_range(0, 3) == 0) put(1'b0, 1'($urandom_range(0, 1)), rnd_full(), rnd_full());
      else begin put(1'b1, i == 0, rnd_full(), rnd_full()); i++; end
    end
    idle(5);
    n_cmp++;
    if (obs_q.size() < N_BIN + 1 || obs_q[N_BIN-1].idx !== 9'd256 || obs_q[N_BIN-1].done !== 1'b1 ||
        obs_q[N_BIN].idx !== 9'd0 || obs_q[N_BIN].edge_no - obs_q[N_BIN-1].edge_no != 256) begin
      n_bad++; $display("FAIL full_frames boundary: got %0d outputs want idx 256 done then idx 0 after 256 edges", obs_q.size());
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL full_frames bin_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
      n_cmp++;
      if (obs_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL full_frames out[%0d]: got %p want %p", j, obs_q[j], exp_q[j]); end
    end
    n_cmp++;
    if (err_obs.size() != err_exp.size()) begin n_bad++; $display("FAIL full_frames sof_err_count: got %0d want %0d", err_obs.size(), err_exp.size()); end
    obs_q.delete(); exp_q.delete(); err_obs.delete(); err_exp.delete();
  endtask

  task automatic test_sof_abort;
    int n_done = 0;
    for (int k = 0; k < 100; k++) put(1'b1, k == 0, rnd_full(), rnd_full());
    for (int k = 0; k < N_FFT; k++) put(1'b1, k == 0, rnd_full(), rnd_full());
    idle(5);
    foreach (obs_q[j]) if (obs_q[j].done) n_done++;
    n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL sof_abort frame_done_count: got %0d want 1", n_done); end
    n_cmp++;
    if (obs_q.size() <= 100 || obs_q[100].idx !== 9'd0) begin
      n_bad++; $display("FAIL sof_abort restart_idx: got %0d want 0", (obs_q.size() <= 100) ? -1 : int'(obs_q[100].idx));
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL sof_abort bin_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
      n_cmp++;
      if (obs_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL sof_abort out[%0d]: got %p want %p", j, obs_q[j], exp_q[j]); end
    end
    n_cmp++;
    if (err_obs.size() != err_exp.size() || err_exp.size() != 1) begin
      n_bad++; $display("FAIL sof_abort sof_err_count: got %0d want %0d", err_obs.size(), err_exp.size());
    end
    for (int j = 0; j < err_obs.size() && j < err_exp.size(); j++) begin
      n_cmp++;
      if (err_obs[j] != err_exp[j]) begin n_bad++; $display("FAIL sof_abort sof_err_edge: got %0d want %0d", err_obs[j], err_exp[j]); end
    end
    obs_q.delete(); exp_q.delete(); err_obs.delete(); err_exp.delete();
  endtask

  task automatic test_reset_mid_frame;
    int i = 0;
    while (i < 50) begin
      if ($urandom_range(0, 2) == 0) put(1'b0, 1'b0, rnd_full(), rnd_full());
      else begin put(1'b1, i == 0, rnd_full(), rnd_full()); i++; end
    end
    @(negedge clk);
    rst = 1'b1;
    fft_vld = 1'b0;
    #1;
    while (exp_q.size() > 0 && exp_q[$].edge_no > edge_n) void'(exp_q.pop_back());
    m_in = 1'b0;
    n_cmp++; if (fft_bin_vld !== 1'b0) begin n_bad++; $display("FAIL mid_reset fft_bin_vld: got %b want 0", fft_bin_vld); end
    n_cmp++; if (fft_bin !== 16'h0)    begin n_bad++; $display("FAIL mid_reset fft_bin: got %h want 0000", fft_bin); end
    n_cmp++; if (fft_bin_idx !== 9'h0) begin n_bad++; $display("FAIL mid_reset fft_bin_idx: got %0d want 0", fft_bin_idx); end
    n_cmp++; if (frame_done !== 1'b0)  begin n_bad++; $display("FAIL mid_reset frame_done: got %b want 0", frame_done); end
    n_cmp++; if (sof_err !== 1'b0)     begin n_bad++; $display("FAIL mid_reset sof_err: got %b want 0", sof_err); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) put(1'($urandom_range(0, 1)), 1'b0, rnd_full(), rnd_full());
    i = 0;
    while (i < N_FFT) begin
      if ($urandom_range(0, 2) == 0) put(1'b0, 1'b0, rnd_full(), rnd_full());
      else begin put(1'b1, i == 0, rnd_full(), rnd_full()); i++; end
    end
    idle(5);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL mid_reset bin_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
      n_cmp++;
      if (obs_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL mid_reset out[%0d]: got %p want %p", j, obs_q[j], exp_q[j]); end
    end
    n_cmp++;
    if (err_obs.size() != 0) begin n_bad++; $display("FAIL mid_reset sof_err_count: got %0d want 0", err_obs.size()); end
    obs_q.delete(); exp_q.delete(); err_obs.delete(); err_exp.delete();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_full_frames();
    test_sof_abort();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
